// File: rtl/status_stack_if.sv
// Flag-register bus between the decoder/condition logic and status_stack.
// The control unit drives op/wr_mask/wr_data. The register returns the flag
// word, the stack occupancy and the fault status.
interface status_stack_if #(
    parameter int FLAG_W = 5,
    parameter int PTR_W  = 3
);
    logic [2:0]        op;
    logic [FLAG_W-1:0] wr_mask;
    logic [FLAG_W-1:0] wr_data;
    logic [FLAG_W-1:0] flags;
    logic [PTR_W-1:0]  depth;
    logic              empty;
    logic              full;
    logic              stack_fault;

    // Control unit side: issues one op per cycle and consumes the flags.
    modport master (
        output op, wr_mask, wr_data,
        input  flags, depth, empty, full, stack_fault
    );

    // Flag register side.
    modport slave (
        input  op, wr_mask, wr_data,
        output flags, depth, empty, full, stack_fault
    );
endinterface

// File: rtl/status_stack.sv
// Processor status-flag register with a hardware save/restore stack.
// The register updates flags under a per-bit mask. On interrupt entry it saves
// the whole flag word. On return it restores that word, so nested handlers
// get their caller's flags back exactly. All state changes on the falling
// edge of clock. The datapath then samples the outputs on the next rising edge.
module status_stack #(
    parameter int FLAG_W = 5,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 3
) (
    input logic           clock,
    input logic           reset,
    status_stack_if.slave bus
);

    typedef enum logic [2:0] {
        OP_HOLD     = 3'd0,
        OP_WRITE    = 3'd1,
        OP_PUSH     = 3'd2,
        OP_POP      = 3'd3,
        OP_TOGGLE   = 3'd4,
        OP_SETALL   = 3'd5,
        OP_CLEAR    = 3'd6,
        OP_CLRFAULT = 3'd7
    } op_e;

    // Width of a stack slot index. A one-entry stack still gets a 1-bit index.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Architectural state.
    logic [FLAG_W-1:0] flags_q;
    logic [PTR_W-1:0]  depth_q;
    logic              fault_q;

    // Next-state values.
    logic [FLAG_W-1:0] flags_d;
    logic [PTR_W-1:0]  depth_d;
    logic              fault_d;

    // Save stack. Slot i holds the i-th saved word, counted from the bottom.
    logic [FLAG_W-1:0] stack_mem [DEPTH];
    logic              push_we;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    logic              is_empty;
    logic              is_full;
    logic [FLAG_W-1:0] merged;
    op_e               op;

    assign op       = op_e'(bus.op);
    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == PTR_W'(DEPTH));

    // A push writes the first free slot. A pop reads the topmost occupied slot.
    // Neither index is used when the matching full/empty check rejects the op.
    assign wr_idx = IDX_W'(depth_q);
    assign rd_idx = IDX_W'(depth_q - PTR_W'(1));

    // Masked merge shared by WRITE and PUSH. Bits outside wr_mask keep their value.
    assign merged = (flags_q & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);

    // Decode the op into next flags, depth, fault and the stack write strobe.
    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no op path can leave one unassigned and infer a latch.
        flags_d = flags_q;
        depth_d = depth_q;
        fault_d = fault_q;
        push_we = 1'b0;

        case (op)
            OP_HOLD: begin
            end
            OP_WRITE: begin
                flags_d = merged;
            end
            OP_PUSH: begin
                if (is_full) begin
                    fault_d = 1'b1;
                end else begin
                    push_we = 1'b1;
                    depth_d = depth_q + PTR_W'(1);
                    flags_d = merged;
                end
            end
            OP_POP: begin
                if (is_empty) begin
                    fault_d = 1'b1;
                end else begin
                    flags_d = stack_mem[rd_idx];
                    depth_d = depth_q - PTR_W'(1);
                end
            end
            OP_TOGGLE: begin
                flags_d = flags_q ^ bus.wr_mask;
            end
            OP_SETALL: begin
                flags_d = '1;
            end
            OP_CLEAR: begin
                flags_d = flags_q & ~bus.wr_mask;
            end
            OP_CLRFAULT: begin
                fault_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Commit flags, depth and fault on the falling edge. Synchronous reset wins.
    always_ff @(negedge clock) begin
        // NOTE: state registers use non-blocking assignments. Every register
        // then samples the old values of the others, which lets a PUSH read
        // the flags it is about to overwrite.
        if (reset) begin
            flags_q <= '0;
            depth_q <= '0;
            fault_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            fault_q <= fault_d;
        end
    end

    // Save the pre-push flag word into the first free stack slot.
    always_ff @(negedge clock) begin
        // NOTE: the stack RAM has no reset. Depth gates every read, so a slot
        // is never read before a push has written it. This keeps the array
        // mappable to plain storage without a reset path.
        if (push_we && !reset) begin
            stack_mem[wr_idx] <= flags_q;
        end
    end

    assign bus.flags       = flags_q;
    assign bus.depth       = depth_q;
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.stack_fault = fault_q;

endmodule

// File: tb/tb_status_stack.sv
// Self-checking bench for status_stack.
// A queue-based reference model tracks flags, the save stack and the sticky
// fault. Directed scenarios run first, followed by randomized op sequences.
module tb_status_stack;

    localparam int FLAG_W = 5;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 3;

    localparam logic [2:0] HOLD     = 3'd0;
    localparam logic [2:0] WRITE    = 3'd1;
    localparam logic [2:0] PUSH     = 3'd2;
    localparam logic [2:0] POP      = 3'd3;
    localparam logic [2:0] TOGGLE   = 3'd4;
    localparam logic [2:0] SETALL   = 3'd5;
    localparam logic [2:0] CLEAR    = 3'd6;
    localparam logic [2:0] CLRFAULT = 3'd7;

    localparam logic [FLAG_W-1:0] ALL = '1;

    logic clock;
    logic reset;

    status_stack_if #(.FLAG_W(FLAG_W), .PTR_W(PTR_W)) bus ();

    status_stack #(.FLAG_W(FLAG_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [FLAG_W-1:0] m_flags;
    logic [FLAG_W-1:0] m_stack [$];
    logic              m_fault;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Update the model for one op, following the architectural rules.
    task automatic model_op(input logic rst, input logic [2:0] op,
                            input logic [FLAG_W-1:0] mask,
                            input logic [FLAG_W-1:0] data);
        if (rst) begin
            m_flags = '0;
            m_stack.delete();
            m_fault = 1'b0;
        end else begin
            case (op)
                WRITE:    m_flags = (m_flags & ~mask) | (data & mask);
                PUSH: begin
                    if (m_stack.size() == DEPTH) begin
                        m_fault = 1'b1;
                    end else begin
                        m_stack.push_back(m_flags);
                        m_flags = (m_flags & ~mask) | (data & mask);
                    end
                end
                POP: begin
                    if (m_stack.size() == 0) m_fault = 1'b1;
                    else m_flags = m_stack.pop_back();
                end
                TOGGLE:   m_flags = m_flags ^ mask;
                SETALL:   m_flags = '1;
                CLEAR:    m_flags = m_flags & ~mask;
                CLRFAULT: m_fault = 1'b0;
                default:  ;
            endcase
        end
    endtask

    // Apply one op: drive it, let the falling edge commit it, then compare
    // all outputs against the model on the following rising edge.
    task automatic step(input logic rst, input logic [2:0] op,
                        input logic [FLAG_W-1:0] mask,
                        input logic [FLAG_W-1:0] data);
        reset       = rst;
        bus.op      = op;
        bus.wr_mask = mask;
        bus.wr_data = data;
        @(negedge clock);
        model_op(rst, op, mask, data);
        @(posedge clock);
        check("flags", 32'(bus.flags), 32'(m_flags));
        check("depth", 32'(bus.depth), 32'(m_stack.size()));
        check("empty", 32'(bus.empty), 32'(m_stack.size() == 0));
        check("full",  32'(bus.full),  32'(m_stack.size() == DEPTH));
        check("fault", 32'(bus.stack_fault), 32'(m_fault));
    endtask

    initial begin
        logic [2:0] rop;
        int         sel;
        m_flags     = '0;
        m_fault     = 1'b0;
        reset       = 1'b1;
        bus.op      = HOLD;
        bus.wr_mask = '0;
        bus.wr_data = '0;

        // Reset, then a masked write.
        step(1'b1, HOLD, '0, '0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        step(1'b0, WRITE, 5'b11110, 5'b10101);
        check("write_merge", 32'(bus.flags), 32'h14);

        // A single push/pop round trip preserves unmasked bits.
        step(1'b0, WRITE, ALL, 5'b01000);
        step(1'b0, PUSH, 5'b00001, 5'b00001);
        check("push_flags", 32'(bus.flags), 32'h09);
        check("push_depth", 32'(bus.depth), 32'd1);
        step(1'b0, POP, 5'b10101, 5'b11111);
        check("pop_flags", 32'(bus.flags), 32'h08);

        // Fill the stack, overflow it, then drain it.
        for (int i = 1; i <= 4; i++) step(1'b0, PUSH, ALL, FLAG_W'(i));
        check("fill_full", 32'(bus.full), 32'd1);
        step(1'b0, PUSH, ALL, 5'd9);
        check("ovf_flags", 32'(bus.flags), 32'd4);
        check("ovf_fault", 32'(bus.stack_fault), 32'd1);
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, POP, '0, '0);
            check("drain", 32'(bus.flags), (i == 0) ? 32'h08 : 32'(i));
        end
        step(1'b0, CLRFAULT, '0, '0);

        // Underflow from reset; fault is sticky across a write.
        step(1'b1, HOLD, '0, '0);
        step(1'b0, POP, '0, '0);
        check("udf_fault", 32'(bus.stack_fault), 32'd1);
        step(1'b0, WRITE, ALL, 5'b00111);
        check("sticky_fault", 32'(bus.stack_fault), 32'd1);
        step(1'b0, CLRFAULT, '0, '0);
        check("clrfault", 32'(bus.stack_fault), 32'd0);

        // Toggle, set-all and clear.
        step(1'b0, WRITE, ALL, 5'b00001);
        step(1'b0, TOGGLE, 5'b00001, '0);
        check("toggle", 32'(bus.flags), 32'h00);
        step(1'b0, SETALL, '0, '0);
        check("setall", 32'(bus.flags), 32'h1f);
        step(1'b0, CLEAR, 5'b10010, '0);
        check("clear", 32'(bus.flags), 32'h0d);

        // Reset in the middle of a stack abandons its entries.
        step(1'b0, PUSH, ALL, 5'd3);
        step(1'b0, PUSH, ALL, 5'd6);
        step(1'b1, HOLD, '0, '0);
        check("midrst_depth", 32'(bus.depth), 32'd0);
        step(1'b0, POP, '0, '0);
        check("midrst_pop_fault", 32'(bus.stack_fault), 32'd1);

        // Randomized op sequences, biased toward push/pop traffic.
        for (int n = 0; n < 2000; n++) begin
            sel = int'($urandom_range(0, 11));
            if (sel > 7) rop = (sel[0]) ? POP : PUSH;
            else rop = 3'(sel);
            step(($urandom_range(0, 99) < 2), rop,
                 FLAG_W'($urandom), FLAG_W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
